// File: rtl/gppcu_stall_gen.sv
// Register scoreboard for the GPPCU decode stage: one busy bit per register, RAW/WAW hazard detection.
// Optional macro GPPCU_STALL_WB_BYPASS_EN lets a same-cycle writeback un-stall a waiting instruction.
module gppcu_stall_gen #(
    parameter int NUMREG = 32,
    parameter int RBW    = $clog2(NUMREG)
) (
    input  logic              iACLK,
    input  logic              iRST,
    input  logic [RBW-1:0]    iREGD,
    input  logic [RBW-1:0]    iREGA,
    input  logic [RBW-1:0]    iREGB,
    input  logic              iVALID_REGD,
    input  logic              iVALID_REGA,
    input  logic              iVALID_REGB,
    input  logic              iHOLD,
    input  logic [RBW-1:0]    iWRREG,
    input  logic              iWRREG_VALID,
    output logic              oENABLED,
    output logic [NUMREG-1:0] oBUSY_MASK
);

    logic [NUMREG-1:0] r_busy;
    logic [NUMREG-1:0] w_wb_mask;
    logic [NUMREG-1:0] w_set_mask;
    logic [NUMREG-1:0] w_busy_eff;
    logic [NUMREG-1:0] w_busy_nxt;
    logic              w_hazard;
    logic              w_issue;

    always_comb begin
        w_wb_mask  = '0;
        w_set_mask = '0;
        if (iWRREG_VALID) begin
            w_wb_mask[iWRREG] = 1'b1;
        end
`ifdef GPPCU_STALL_WB_BYPASS_EN
        // A register completing writeback this cycle no longer blocks readers or writers.
        w_busy_eff = r_busy & ~w_wb_mask;
`else
        w_busy_eff = r_busy;
`endif
        w_hazard = (iVALID_REGA & w_busy_eff[iREGA]) |
                   (iVALID_REGB & w_busy_eff[iREGB]) |
                   (iVALID_REGD & w_busy_eff[iREGD]);
        w_issue  = ~w_hazard & iVALID_REGD & ~iHOLD;
        if (w_issue) begin
            w_set_mask[iREGD] = 1'b1;
        end
        // Set is applied after clear so a same-register issue/writeback leaves the bit pending.
        w_busy_nxt = (r_busy & ~w_wb_mask) | w_set_mask;
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign oENABLED   = ~w_hazard;
    assign oBUSY_MASK = r_busy;

endmodule

// File: tb/tb_gppcu_stall_gen.sv
// Directed table-driven bench for gppcu_stall_gen; expectations adapt to GPPCU_STALL_WB_BYPASS_EN.
module tb_gppcu_stall_gen;

`ifdef GPPCU_STALL_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        iACLK = 1'b0;
    logic        iRST;
    logic [4:0]  iREGD, iREGA, iREGB, iWRREG;
    logic        iVALID_REGD, iVALID_REGA, iVALID_REGB, iHOLD, iWRREG_VALID;
    logic        oENABLED;
    logic [31:0] oBUSY_MASK;

    int n_tests = 0;
    int n_fail  = 0;

    gppcu_stall_gen dut (
        .iACLK        (iACLK),
        .iRST         (iRST),
        .iREGD        (iREGD),
        .iREGA        (iREGA),
        .iREGB        (iREGB),
        .iVALID_REGD  (iVALID_REGD),
        .iVALID_REGA  (iVALID_REGA),
        .iVALID_REGB  (iVALID_REGB),
        .iHOLD        (iHOLD),
        .iWRREG       (iWRREG),
        .iWRREG_VALID (iWRREG_VALID),
        .oENABLED     (oENABLED),
        .oBUSY_MASK   (oBUSY_MASK)
    );

    always #5 iACLK = ~iACLK;

    typedef struct {
        logic        rst;
        logic        vd, va, vb, hold, wrv;
        logic [4:0]  d, a, b, wr;
        logic        exp_en;
        logic [31:0] exp_mask;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vd, input logic [4:0] d,
                       input logic va, input logic [4:0] a,
                       input logic vb, input logic [4:0] b,
                       input logic hold, input logic wrv, input logic [4:0] wr,
                       input logic exp_en, input logic [31:0] exp_mask);
        vec_t v;
        v.rst = rst; v.vd = vd; v.d = d; v.va = va; v.a = a; v.vb = vb; v.b = b;
        v.hold = hold; v.wrv = wrv; v.wr = wr; v.exp_en = exp_en; v.exp_mask = exp_mask;
        vecs.push_back(v);
    endtask

    task automatic check_en(input string name, input logic exp);
        n_tests++;
        if (oENABLED !== exp) begin
            n_fail++;
            $display("FAIL %s oENABLED got %0b expected %0b", name, oENABLED, exp);
        end
    endtask

    task automatic check_mask(input string name, input logic [31:0] exp);
        n_tests++;
        if (oBUSY_MASK !== exp) begin
            n_fail++;
            $display("FAIL %s oBUSY_MASK got %08h expected %08h", name, oBUSY_MASK, exp);
        end
    endtask

    // Drives one cycle: inputs are set after an edge, enable checked before the next edge, mask after it.
    task automatic step(input vec_t v, input string name);
        iRST = v.rst; iVALID_REGD = v.vd; iREGD = v.d; iVALID_REGA = v.va; iREGA = v.a;
        iVALID_REGB = v.vb; iREGB = v.b; iHOLD = v.hold; iWRREG_VALID = v.wrv; iWRREG = v.wr;
        #1;
        check_en({name, "_en"}, v.exp_en);
        @(posedge iACLK);
        #1;
        check_mask({name, "_mask"}, v.exp_mask);
    endtask

    initial begin
        vec_t h;
        //   rst vd d   va a   vb b   hold wrv wr  en        mask
        add(1, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1, 32'h0);                      // 0 reset
        add(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  1, 32'h0);                      // 1 idle
        add(0, 1, 3,  0, 0,  0, 0,  0, 0, 0,  1, 32'h8);                      // 2 issue D=3
        add(0, 0, 0,  1, 3,  0, 0,  0, 0, 0,  0, 32'h8);                      // 3 RAW on 3
        add(0, 0, 0,  1, 3,  0, 0,  0, 1, 3,  BYP, 32'h0);                    // 4 writeback 3
        add(0, 0, 0,  1, 3,  0, 0,  0, 0, 0,  1, 32'h0);                      // 5 reader free
        add(0, 1, 5,  0, 0,  0, 0,  0, 1, 5,  1, 32'h20);                     // 6 issue+wb 5, set wins
        add(0, 1, 5,  0, 0,  0, 0,  0, 1, 5,  BYP, BYP ? 32'h20 : 32'h0);     // 7 same while busy
        add(0, 1, 5,  0, 0,  0, 0,  0, 0, 0,  ~BYP, 32'h20);                  // 8 realign state
        add(0, 1, 6,  0, 0,  0, 0,  0, 1, 5,  1, 32'h40);                     // 9 issue 6, wb 5
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 6,  1, 32'h0);                      // 10 wb 6
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 12, 1, 32'h0);                      // 11 wb idle reg
        add(0, 1, 4,  0, 0,  0, 0,  1, 0, 0,  1, 32'h0);                      // 12 hold blocks set
        add(0, 1, 4,  1, 4,  1, 4,  0, 0, 0,  1, 32'h10);                     // 13 D=A=B=4 free
        add(0, 1, 4,  1, 4,  1, 4,  0, 0, 0,  0, 32'h10);                     // 14 D=A=B=4 busy
        add(0, 1, 4,  1, 4,  1, 4,  1, 1, 4,  BYP, 32'h0);                    // 15 hold, clear still
        add(0, 1, 2,  0, 0,  0, 0,  0, 0, 0,  1, 32'h4);                      // 16 issue 2
        add(0, 1, 9,  0, 0,  0, 0,  0, 0, 0,  1, 32'h204);                    // 17 issue 9
        add(0, 0, 2,  0, 2,  0, 9,  0, 0, 0,  1, 32'h204);                    // 18 valids low
        add(1, 1, 1,  0, 0,  0, 0,  0, 1, 2,  1, 32'h0);                      // 19 reset mid-op
        add(0, 0, 0,  1, 2,  1, 9,  0, 0, 0,  1, 32'h0);                      // 20 after reset
        add(0, 1, 0,  0, 0,  0, 0,  0, 0, 0,  1, 32'h1);                      // 21 issue reg 0
        add(0, 0, 0,  0, 0,  1, 0,  0, 0, 0,  0, 32'h1);                      // 22 RAW on reg 0
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 0,  1, 32'h0);                      // 23 wb reg 0
        add(0, 1, 31, 0, 0,  1, 31, 0, 0, 0,  1, 32'h80000000);               // 24 top register
        add(0, 0, 0,  0, 0,  0, 0,  0, 1, 31, 1, 32'h0);                      // 25 wb 31

        @(posedge iACLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Held WAW-free write to 7: bit must stay clear through the hold, set once on release.
        h = '{rst: 0, vd: 1, d: 7, va: 0, a: 0, vb: 0, b: 0, hold: 1, wrv: 0, wr: 0,
              exp_en: 1, exp_mask: 32'h0};
        for (int c = 0; c < 3; c++) begin
            step(h, $sformatf("hold%0d", c));
        end
        h.hold = 0; h.exp_mask = 32'h80;
        step(h, "release");
        h.exp_en = 0;
        step(h, "waw7");
        h.vd = 0; h.wrv = 1; h.wr = 7; h.exp_en = 1; h.exp_mask = 32'h0;
        step(h, "clear7");

        // Reset with 2 and 9 pending, one edge.
        h = '{rst: 0, vd: 1, d: 2, va: 0, a: 0, vb: 0, b: 0, hold: 0, wrv: 0, wr: 0,
              exp_en: 1, exp_mask: 32'h4};
        step(h, "set2");
        h.d = 9; h.exp_mask = 32'h204;
        step(h, "set9");
        h.rst = 1; h.vd = 0; h.exp_mask = 32'h0;
        step(h, "rst29");
        h.rst = 0; h.va = 1; h.a = 2; h.vb = 1; h.b = 9; h.vd = 1; h.d = 9; h.exp_mask = 32'h200;
        step(h, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
